// File: rtl/irq_pending_latch_pkg.sv
// Shared definitions for the interrupt pending latch: FSM state encoding,
// request/id widths, and the id-to-one-hot helper used to clear a pending bit.
package irq_pending_latch_pkg;

    localparam int N_REQ = 8;
    localparam int ID_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        CLEAR = 2'd2
    } state_t;

    // One-hot vector (index 0 on the left) selecting the line named by id.
    function automatic logic [0:N_REQ-1] id_to_onehot(input logic [ID_W-1:0] id);
        logic [0:N_REQ-1] oh;
        oh     = '0;
        oh[id] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/irq_pending_latch_priority_encoder.sv
// priorityEncoder: 8-to-3 encoder, highest set index wins; inValid flags an
// all-zero input.
module priorityEncoder
    import irq_pending_latch_pkg::*;
(
    input  logic [0:N_REQ-1] x,
    output logic [ID_W-1:0]  y,
    output logic             inValid
);

    // Later (higher) indices overwrite earlier ones, giving bit 7 priority.
    always_comb begin
        y       = '0;
        inValid = (x == '0);
        for (int i = 0; i < N_REQ; i++) begin
            if (x[i]) y = ID_W'(i);
        end
    end

endmodule

// File: rtl/irq_pending_latch.sv
// irq_pending_latch: edge-detects request lines into a pending vector and
// offers the highest-priority unmasked pending id through a small handshake.
//
//   state | meaning
//   IDLE  | nothing offered; capture encoder id when any unmasked bit pends
//   OFFER | irq_id held stable until irq_ack
//   CLEAR | one-cycle gap after an ack before the next offer
//
// Build option: define IRQ_PENDING_SYNC_EN to insert a 2-flop synchroniser on
// req ahead of edge detection (adds two cycles of latency).
module irq_pending_latch
    import irq_pending_latch_pkg::*;
#(
    parameter int N_REQ = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [0:N_REQ-1] req,
    input  logic [0:N_REQ-1] mask,
    input  logic             irq_ack,
    output logic             irq_valid,
    output logic [0:ID_W-1]  irq_id,
    output logic [0:N_REQ-1] pending
);

    state_t           state;
    state_t           state_nxt;
    logic [0:N_REQ-1] req_s;
    logic [0:N_REQ-1] req_d;
    logic [0:N_REQ-1] rise;
    logic [0:N_REQ-1] clr;
    logic [ID_W-1:0]  enc_y;
    logic             enc_in_valid;
    logic             armed;

`ifdef IRQ_PENDING_SYNC_EN
    logic [0:N_REQ-1] sync1;
    logic [0:N_REQ-1] sync2;
    logic [2:0]       arm_q;

    // Two-flop synchroniser for asynchronous request sources.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= req;
            sync2 <= sync1;
        end
    end

    // Edge detection stays disarmed until req_d holds a real synchronised
    // sample, so lines already high at reset release are not seen as edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) arm_q <= '0;
        else        arm_q <= {arm_q[1:0], 1'b1};
    end

    assign req_s = sync2;
    assign armed = arm_q[2];
`else
    logic arm_q;

    // Disarm the first clock after reset so req_d can load the current level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) arm_q <= 1'b0;
        else        arm_q <= 1'b1;
    end

    assign req_s = req;
    assign armed = arm_q;
`endif

    assign rise = armed ? (req_s & ~req_d) : '0;
    assign clr  = (state == OFFER && irq_ack) ? id_to_onehot(irq_id) : '0;

    // Delayed request copy and pending vector; a set in the same cycle as a
    // clear wins so the new event is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_d   <= '0;
            pending <= '0;
        end else begin
            req_d   <= req_s;
            pending <= (pending & ~clr) | rise;
        end
    end

    priorityEncoder u_enc (
        .x       (pending & ~mask),
        .y       (enc_y),
        .inValid (enc_in_valid)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!enc_in_valid) state_nxt = OFFER;
            OFFER:   if (irq_ack)       state_nxt = CLEAR;
            CLEAR:                      state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // Offered id is captured only on the IDLE->OFFER edge and then frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               irq_id <= '0;
        else if (state == IDLE && !enc_in_valid)  irq_id <= enc_y;
    end

    // Output decode.
    always_comb begin
        irq_valid = (state == OFFER);
    end

endmodule

// File: tb/tb_irq_pending_latch.sv
// Directed bench for irq_pending_latch (default build: no synchroniser).
// Inputs change 1 ns after a rising edge; outputs are checked at that point.
module tb_irq_pending_latch;

    logic       clk;
    logic       rst_n;
    logic [0:7] req;
    logic [0:7] mask;
    logic       irq_ack;
    logic       irq_valid;
    logic [0:2] irq_id;
    logic [0:7] pending;

    int errors = 0;
    int checks = 0;

    irq_pending_latch #(.N_REQ(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .mask      (mask),
        .irq_ack   (irq_ack),
        .irq_valid (irq_valid),
        .irq_id    (irq_id),
        .pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = '0; mask = '0; irq_ack = 1'b0;
        tick(); tick();
        checks++;
        if (irq_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", irq_valid); end
        checks++;
        if (irq_id !== 3'd0) begin errors++; $display("FAIL reset_id got=%0d exp=0", irq_id); end
        checks++;
        if (pending !== 8'h00) begin errors++; $display("FAIL reset_pending got=%b exp=00000000", pending); end
        rst_n = 1'b1;
        tick(); tick();
    endtask

    task automatic test_single_edge();
        req = 8'b0000_0100;
        tick();
        checks++;
        if (pending !== 8'b0000_0100) begin errors++; $display("FAIL single_pending got=%b exp=00000100", pending); end
        checks++;
        if (irq_valid !== 1'b0) begin errors++; $display("FAIL single_valid_early got=%b exp=0", irq_valid); end
        req = '0;
        tick();
        checks++;
        if (irq_valid !== 1'b1 || irq_id !== 3'd5) begin errors++; $display("FAIL single_offer got valid=%b id=%0d exp valid=1 id=5", irq_valid, irq_id); end
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        checks++;
        if (pending !== 8'h00 || irq_valid !== 1'b0) begin errors++; $display("FAIL single_clear got pending=%b valid=%b exp 00000000/0", pending, irq_valid); end
        tick();
        checks++;
        if (irq_valid !== 1'b0) begin errors++; $display("FAIL single_idle got=%b exp=0", irq_valid); end
    endtask

    task automatic test_priority();
        req = 8'b1000_0001;
        tick();
        req = '0;
        checks++;
        if (pending !== 8'b1000_0001) begin errors++; $display("FAIL prio_pending got=%b exp=10000001", pending); end
        tick();
        checks++;
        if (irq_valid !== 1'b1 || irq_id !== 3'd7) begin errors++; $display("FAIL prio_first got valid=%b id=%0d exp 1/7", irq_valid, irq_id); end
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        checks++;
        if (pending !== 8'b1000_0000 || irq_valid !== 1'b0) begin errors++; $display("FAIL prio_clear7 got pending=%b valid=%b exp 10000000/0", pending, irq_valid); end
        tick();
        checks++;
        if (irq_valid !== 1'b0) begin errors++; $display("FAIL prio_gap got=%b exp=0", irq_valid); end
        tick();
        checks++;
        if (irq_valid !== 1'b1 || irq_id !== 3'd0) begin errors++; $display("FAIL prio_second got valid=%b id=%0d exp 1/0", irq_valid, irq_id); end
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        checks++;
        if (pending !== 8'h00) begin errors++; $display("FAIL prio_clear0 got=%b exp=00000000", pending); end
        tick();
    endtask

    task automatic test_hold_id();
        req = 8'b0010_0000;
        tick();
        req = '0;
        tick();
        checks++;
        if (irq_valid !== 1'b1 || irq_id !== 3'd2) begin errors++; $display("FAIL hold_offer got valid=%b id=%0d exp 1/2", irq_valid, irq_id); end
        req = 8'b0000_0010;
        tick();
        req = '0;
        checks++;
        if (pending !== 8'b0010_0010 || irq_id !== 3'd2) begin errors++; $display("FAIL hold_stable got pending=%b id=%0d exp 00100010/2", pending, irq_id); end
        tick();
        checks++;
        if (irq_valid !== 1'b1 || irq_id !== 3'd2) begin errors++; $display("FAIL hold_still got valid=%b id=%0d exp 1/2", irq_valid, irq_id); end
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        checks++;
        if (pending !== 8'b0000_0010) begin errors++; $display("FAIL hold_clear got=%b exp=00000010", pending); end
        tick(); tick();
        checks++;
        if (irq_valid !== 1'b1 || irq_id !== 3'd6) begin errors++; $display("FAIL hold_next got valid=%b id=%0d exp 1/6", irq_valid, irq_id); end
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        tick();
    endtask

    task automatic test_mask();
        mask = 8'b0000_0001;
        req  = 8'b0000_0001;
        tick();
        req = '0;
        checks++;
        if (pending !== 8'b0000_0001) begin errors++; $display("FAIL mask_pending got=%b exp=00000001", pending); end
        tick();
        req = 8'b0000_0001;
        tick();
        req = '0;
        tick();
        checks++;
        if (irq_valid !== 1'b0 || pending !== 8'b0000_0001) begin errors++; $display("FAIL mask_hidden got valid=%b pending=%b exp 0/00000001", irq_valid, pending); end
        mask = '0;
        tick(); tick();
        checks++;
        if (irq_valid !== 1'b1 || irq_id !== 3'd7) begin errors++; $display("FAIL mask_release got valid=%b id=%0d exp 1/7", irq_valid, irq_id); end
        mask = 8'b0000_0001;
        tick();
        checks++;
        if (irq_valid !== 1'b1 || irq_id !== 3'd7) begin errors++; $display("FAIL mask_in_offer got valid=%b id=%0d exp 1/7", irq_valid, irq_id); end
        mask = '0;
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        checks++;
        if (pending !== 8'h00) begin errors++; $display("FAIL mask_coalesce got=%b exp=00000000", pending); end
        tick();
    endtask

    task automatic test_set_wins();
        req = 8'b0001_0000;
        tick();
        req = '0;
        tick();
        checks++;
        if (irq_valid !== 1'b1 || irq_id !== 3'd3) begin errors++; $display("FAIL setwin_offer got valid=%b id=%0d exp 1/3", irq_valid, irq_id); end
        tick();
        req     = 8'b0001_0000;
        irq_ack = 1'b1;
        tick();
        req     = '0;
        irq_ack = 1'b0;
        checks++;
        if (pending !== 8'b0001_0000 || irq_valid !== 1'b0) begin errors++; $display("FAIL setwin_kept got pending=%b valid=%b exp 00010000/0", pending, irq_valid); end
        tick(); tick();
        checks++;
        if (irq_valid !== 1'b1 || irq_id !== 3'd3) begin errors++; $display("FAIL setwin_reoffer got valid=%b id=%0d exp 1/3", irq_valid, irq_id); end
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        checks++;
        if (pending !== 8'h00) begin errors++; $display("FAIL setwin_clear got=%b exp=00000000", pending); end
        tick();
    endtask

    task automatic test_reset_mid_offer();
        req = 8'b0100_0000;
        tick(); tick();
        checks++;
        if (irq_valid !== 1'b1 || irq_id !== 3'd1) begin errors++; $display("FAIL rstmid_offer got valid=%b id=%0d exp 1/1", irq_valid, irq_id); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (irq_valid !== 1'b0 || pending !== 8'h00) begin errors++; $display("FAIL rstmid_async got valid=%b pending=%b exp 0/00000000", irq_valid, pending); end
        #2 rst_n = 1'b1;
        tick(); tick(); tick();
        checks++;
        if (irq_valid !== 1'b0 || pending !== 8'h00) begin errors++; $display("FAIL rstmid_level got valid=%b pending=%b exp 0/00000000", irq_valid, pending); end
        req = '0;
        tick();
        req = 8'b0100_0000;
        tick();
        checks++;
        if (pending !== 8'b0100_0000) begin errors++; $display("FAIL rstmid_reedge got=%b exp=01000000", pending); end
        tick();
        checks++;
        if (irq_valid !== 1'b1 || irq_id !== 3'd1) begin errors++; $display("FAIL rstmid_reoffer got valid=%b id=%0d exp 1/1", irq_valid, irq_id); end
        req     = '0;
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_edge();
        test_priority();
        test_hold_id();
        test_mask();
        test_set_wins();
        test_reset_mid_offer();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
